// File: rtl/hex_pkg.sv
// ----------------------------------------------------------------------------
// hex_pkg
// Shared types and helpers for the multiplexed seven-segment display path.
//   seg_t        : one display's active-low segments, bit order gfedcba
//   SEG_OFF      : segment pattern with every segment dark
//   scan_state_t : sequencer states of hex_scan_ctrl
//   lzb_mask()   : leading-zero blanking mask (used when HEX_LZB_EN is defined)
// ----------------------------------------------------------------------------
package hex_pkg;

   typedef logic [6:0] seg_t;

   localparam seg_t SEG_OFF    = 7'h7F;
   localparam int   MAX_DIGITS = 8;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      COMMIT
   } scan_state_t;

   // Marks every digit above the most significant nonzero nibble. Digit 0 is
   // never marked, so an all-zero value still shows a single "0".
   function automatic logic [MAX_DIGITS-1:0] lzb_mask(
      input logic [4*MAX_DIGITS-1:0] value,
      input int                      num_digits
   );
      logic seen;
      lzb_mask = '0;
      seen     = 1'b0;
      for (int d = MAX_DIGITS - 1; d >= 1; d--) begin
         if (d < num_digits) begin
            if (value[4*d +: 4] != 4'h0) seen = 1'b1;
            if (!seen) lzb_mask[d] = 1'b1;
         end
      end
   endfunction

endpackage

// File: rtl/hexdd.sv
// ----------------------------------------------------------------------------
// hexdd
// Combinational nibble-to-seven-segment decoder, active-low, gfedcba.
//   nibble_i : hex digit 0..F
//   seg_o    : segment pattern (0 = segment lit)
// ----------------------------------------------------------------------------
module hexdd
   import hex_pkg::*;
(
   input  logic [3:0] nibble_i,
   output seg_t       seg_o
);

   always_comb begin
      // NOTE: every path assigns seg_o (default arm), so no latch is inferred.
      unique case (nibble_i)
         4'h0:    seg_o = 7'h40;
         4'h1:    seg_o = 7'h79;
         4'h2:    seg_o = 7'h24;
         4'h3:    seg_o = 7'h30;
         4'h4:    seg_o = 7'h19;
         4'h5:    seg_o = 7'h12;
         4'h6:    seg_o = 7'h02;
         4'h7:    seg_o = 7'h78;
         4'h8:    seg_o = 7'h00;
         4'h9:    seg_o = 7'h10;
         4'hA:    seg_o = 7'h08;
         4'hB:    seg_o = 7'h03;
         4'hC:    seg_o = 7'h46;
         4'hD:    seg_o = 7'h21;
         4'hE:    seg_o = 7'h06;
         default: seg_o = 7'h0E;
      endcase
   end

endmodule

// File: rtl/hex_scan_ctrl.sv
// ----------------------------------------------------------------------------
// hex_scan_ctrl
// Accepts a packed hex value over valid/ready, walks its digits through one
// shared hexdd decoder (SLOT_CYC cycles per digit) into a staging buffer and
// then commits all digits to the display outputs in a single cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   value_i    : 4*NUM_DIGITS hex value, digit 0 = rightmost display
//   blank_i    : per-digit force-blank mask, sampled with value_i
//   valid_i    : request; accepted only while ready_o is high
//   ready_o    : controller idle
//   disp_o     : 7*NUM_DIGITS active-low segments, digit d at [7d+6:7d]
//   done_o     : one-cycle pulse in the cycle disp_o updates
// Build option: define HEX_LZB_EN to auto-blank leading zero digits.
// ----------------------------------------------------------------------------
module hex_scan_ctrl
   import hex_pkg::*;
#(
   parameter int NUM_DIGITS = 6,
   parameter int SLOT_CYC   = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] value_i,
   input  logic [NUM_DIGITS-1:0]   blank_i,
   input  logic                    valid_i,
   output logic                    ready_o,
   output logic [7*NUM_DIGITS-1:0] disp_o,
   output logic                    done_o
);

   localparam int CNT_W = $clog2(SLOT_CYC);
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_CYC - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   scan_state_t                 state_q;
   logic [CNT_W-1:0]            cnt_q;
   logic [IDX_W-1:0]            idx_q;
   seg_t [NUM_DIGITS-1:0]       staging_q;
   seg_t [NUM_DIGITS-1:0]       disp_q;
   logic                        ready_q;
   logic                        done_q;

   logic [NUM_DIGITS-1:0][3:0]  nib_q;
   logic [NUM_DIGITS-1:0]       blank_q;
   logic [NUM_DIGITS-1:0]       blank_d;
   logic                        accept;
   seg_t                        dec_seg;

   assign accept = valid_i & ready_q;

`ifdef HEX_LZB_EN
   logic [MAX_DIGITS-1:0] lz_full;
   always_comb begin
      lz_full = lzb_mask((4*MAX_DIGITS)'(value_i), NUM_DIGITS);
      blank_d = blank_i | lz_full[NUM_DIGITS-1:0];
   end
`else
   assign blank_d = blank_i;
`endif

   // NOTE: the shadow copy has no reset; it is always written at accept
   // before SCAN reads it, so resetting it would only add enable logic.
   always_ff @(posedge clk) begin
      if (accept) begin
         nib_q   <= value_i;
         blank_q <= blank_d;
      end
   end

   hexdd u_hexdd (
      .nibble_i (nib_q[idx_q]),
      .seg_o    (dec_seg)
   );

   // NOTE: all state updates use <= so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         staging_q <= '1;
         disp_q    <= '1;
         ready_q   <= 1'b1;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  cnt_q   <= '0;
                  idx_q   <= '0;
                  ready_q <= 1'b0;
                  state_q <= SCAN;
               end
            end
            SCAN: begin
               if (cnt_q == CNT_LAST) begin
                  staging_q[idx_q] <= blank_q[idx_q] ? SEG_OFF : dec_seg;
                  cnt_q            <= '0;
                  // Index parks on the last digit rather than wrapping.
                  if (idx_q == IDX_LAST) state_q <= COMMIT;
                  else                   idx_q   <= idx_q + 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            COMMIT: begin
               disp_q  <= staging_q;
               done_q  <= 1'b1;
               ready_q <= 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ready_o = ready_q;
   assign done_o  = done_q;
   assign disp_o  = disp_q;

endmodule

// File: doc/hex_scan_ctrl.md
Name: hex_scan_ctrl

Overview:
- Sequencer that shares one `hexdd` nibble-to-segment decoder across NUM_DIGITS seven-segment displays.
- Accepts a packed multi-digit hex value through a valid/ready handshake.
- Walks the digits through the single decoder, one slot per digit, into a staging buffer.
- Commits all digits atomically to the display outputs. Sits between the core's debug/MMIO register and the board HEX pins.

Parameters:
- NUM_DIGITS, 6: number of displays driven; legal range 1..8.
- SLOT_CYC, 4: clock cycles spent per digit slot; legal minimum 2.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- value_i  input  4*NUM_DIGITS  hex value; digit d is value_i[4d+3:4d], d=0 is the rightmost display.
- blank_i  input  NUM_DIGITS  per-digit force-blank mask, sampled with value_i.
- valid_i  input  1  request to display value_i/blank_i.
- ready_o  output  1  controller idle and able to accept.
- disp_o  output  7*NUM_DIGITS  active-low segments; digit d at [7d+6:7d], bit order gfedcba.
- done_o  output  1  one-cycle pulse in the cycle disp_o updates.

Behaviour:
- Reset (async assert, sync release):
  - disp_o = all 1s (every segment off); ready_o = 1; done_o = 0.
  - Staging buffer = all 1s; FSM = IDLE; digit index = 0; slot counter = 0.
- FSM states: IDLE, SCAN, COMMIT.
- IDLE:
  - ready_o = 1.
  - When valid_i & ready_o: snapshot value_i and blank_i into shadow registers, clear digit index and slot counter, go to SCAN.
  - valid_i while not ready is ignored; it is not queued.
- SCAN:
  - ready_o = 0. Shared decoder input = shadow nibble[digit index].
  - Slot counter counts 0..SLOT_CYC-1.
  - At count SLOT_CYC-1, write to staging[digit index]:
    - 7'h7F if the digit is blanked;
    - otherwise the decoder output.
  - Then increment the digit index and wrap the slot counter to 0.
  - After writing digit NUM_DIGITS-1, go to COMMIT.
- COMMIT (one cycle): disp_o <= staging; done_o = 1; go to IDLE.
- Latency: disp_o and done_o change exactly NUM_DIGITS*SLOT_CYC+1 cycles after the accepting edge. Earliest next accept is the cycle after done_o.
- Between commits disp_o holds its value; intermediate staging never appears on disp_o.
- Slot counter width is $clog2(SLOT_CYC). Digit index width is $clog2(NUM_DIGITS), minimum 1. Neither may wrap past its terminal value.
- Reset mid-SCAN discards the shadow and staging contents; outputs return to their reset values immediately.
- valid_i held high across back-to-back requests: each accept samples the inputs present on that edge.

Optional Feature:
- Macro: HEX_LZB_EN.
- Defined: leading-zero blanking. At accept, digits above the most significant nonzero nibble are marked blank (OR'd with blank_i). Digit 0 is never auto-blanked, so value 0 shows a single "0".
- Undefined: only blank_i blanks digits; zeros always display as "0".
- Handshake and latency are identical in both builds.

Decomposition:
- Package hex_pkg holds:
  - typedef seg_t (logic [6:0]);
  - constant SEG_OFF = 7'h7F;
  - enum scan_state_t {IDLE, SCAN, COMMIT}.
- The single decoder is one instance of the existing `hexdd`; no other sub-module is needed.
- The leading-zero mask is a function in hex_pkg.

Test Plan:
- Reset: hold rst_n=0 -> disp_o all 1s, ready_o=1, done_o=0. Assert rst_n asynchronously mid-SCAN -> outputs return to reset values the same instant.
- Decode (NUM_DIGITS=6, SLOT_CYC=4), value_i=24'h0012A8, blank_i=0:
  - done_o exactly 25 cycles after accept.
  - disp_o digits 0..5 = 00,08,24,79,40,40 (hex).
- Blank mask: value_i=24'hFFFFFF, blank_i=6'b101010 -> digits 0,2,4 = 0E; digits 1,3,5 = 7F.
- Handshake: pulse valid_i during SCAN with 24'h111111 -> ignored; disp_o reflects only the first value; ready_o low for 25 cycles.
- Back-to-back: valid_i held high with 24'h000000 then 24'h888888 -> two done_o pulses 26 cycles apart; final disp_o digits all 00.
- HEX_LZB_EN defined: value 24'h0012A8 -> digits 4,5 = 7F. Value 0 -> digit 0 = 40, digits 1..5 = 7F.
